psum_sram_ctrl: RTL and testbench

//  Initiator for the single-port PSUM SRAM (CEN/WEN active-low, 1-cycle registered read, Q held while CEN high).

---
 rtl/psum_sram_pkg.sv | 33 +++
 rtl/psum_lane_add.sv | 27 ++
 rtl/psum_sram_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_psum_sram_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_sram_pkg.sv
// psum_sram_pkg
// Shared definitions for the PSUM SRAM controller slice: default geometry,
// controller state encoding and the lane-slice helper used by the lane adder.
// Optional feature macro: PSUM_ACC_EN adds the ACC_WR state used by the
// lane-wise read-modify-write accumulation path.
package psum_sram_pkg;

  localparam int PSUM_BW_DEF = 20;
  localparam int LANES_DEF   = 8;
  localparam int AW_DEF      = 4;
  localparam int DEPTH_DEF   = 8;

  // IDLE: no response pending, RSP: read data on rsp_data waiting for the
  // consumer, ACC_WR: second half of an accumulate (write-back cycle).
`ifdef PSUM_ACC_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RSP    = 2'd1,
    ST_ACC_WR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RSP  = 2'd1
  } state_t;
`endif

  // Least significant bit of lane 'lane' inside a packed psum word.
  function automatic int lane_lo(input int lane, input int psum_bw);
    return lane * psum_bw;
  endfunction

endpackage

// File: rtl/psum_lane_add.sv
// psum_lane_add
// Lane-wise adder for packed psum words. Each lane is a two's complement
// value of PSUM_BW bits; sums wrap modulo 2^PSUM_BW and no carry crosses
// a lane boundary. Only instantiated when PSUM_ACC_EN is defined.
// Ports:
//   a    in   LANES*PSUM_BW  stored word (lane i = [i*PSUM_BW +: PSUM_BW])
//   b    in   LANES*PSUM_BW  increment word
//   sum  out  LANES*PSUM_BW  lane-wise wrapped sum
module psum_lane_add
  import psum_sram_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF
) (
  input  logic [LANES*PSUM_BW-1:0] a,
  input  logic [LANES*PSUM_BW-1:0] b,
  output logic [LANES*PSUM_BW-1:0] sum
);

  // A PSUM_BW-bit add already wraps the signed result correctly, so the
  // lanes are plain same-width adds kept apart by the slicing.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sum[lane_lo(i, PSUM_BW) +: PSUM_BW] =
      a[lane_lo(i, PSUM_BW) +: PSUM_BW] + b[lane_lo(i, PSUM_BW) +: PSUM_BW];
  end

endmodule

// File: rtl/psum_sram_ctrl.sv
// psum_sram_ctrl
// Initiator for the single-port PSUM SRAM (CEN/WEN active-low, 1-cycle
// registered read, Q held while CEN is high). Merges a valid/ready write
// channel and a read request/response channel into at most one SRAM op per
// cycle, round-robin between the two, and returns read data with
// backpressure. Optional feature macro: PSUM_ACC_EN enables lane-wise
// read-modify-write accumulation (wr_acc=1 writes).
// Ports:
//   CLK, RESET          clock (posedge), asynchronous active-high reset
//   wr_valid/wr_ready   write request handshake
//   wr_addr, wr_data    write address / data
//   wr_acc              accumulate into stored word (PSUM_ACC_EN only)
//   rd_valid/rd_ready   read request handshake
//   rd_addr             read address
//   rsp_valid/rsp_ready read response handshake
//   rsp_data            read data (0 for an out-of-range read)
//   addr_err            1-cycle pulse after an out-of-range request is accepted
//   sram_cen/sram_wen   SRAM enables, active-low
//   sram_a, sram_d      SRAM address / write data
//   sram_q              SRAM read data
module psum_sram_ctrl
  import psum_sram_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int BW      = LANES * PSUM_BW,
  parameter int AW      = AW_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_data,
  input  logic          wr_acc,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [BW-1:0] rsp_data,
  output logic          addr_err,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [BW-1:0] sram_d,
  input  logic [BW-1:0] sram_q
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t state;
  logic   rr_read;   // 1: read wins the next tie, 0: write wins
  logic   rsp_zero;  // pending response came from an out-of-range read

  logic rd_oor, wr_oor;
  logic rd_elig, wr_elig;
  logic rd_req, wr_req;
  logic rd_fire, wr_fire;
  logic acc_req;

`ifdef PSUM_ACC_EN
  logic [AW-1:0] acc_addr;
  logic [BW-1:0] acc_data;
  logic [BW-1:0] acc_sum;

  assign acc_req = wr_acc;

  psum_lane_add #(
    .LANES   (LANES),
    .PSUM_BW (PSUM_BW)
  ) u_lane_add (
    .a   (sram_q),
    .b   (acc_data),
    .sum (acc_sum)
  );
`else
  logic unused_wr_acc;

  assign acc_req       = 1'b0;
  assign unused_wr_acc = wr_acc;
`endif

  assign rd_oor = {1'b0, rd_addr} >= DEPTH_L;
  assign wr_oor = {1'b0, wr_addr} >= DEPTH_L;

  // A new read may only issue when the response register is free or being
  // emptied this cycle. Plain writes never touch Q, so they may also go while
  // a response is pending; accumulates need Q and go only from IDLE.
  // Nothing is accepted while RESET is high so the SRAM stays disabled.
  assign rd_elig = !RESET && ((state == ST_IDLE) || ((state == ST_RSP) && rsp_ready));
  assign wr_elig = !RESET && ((state == ST_IDLE) || ((state == ST_RSP) && !acc_req));

  assign rd_req = rd_valid && rd_elig;
  assign wr_req = wr_valid && wr_elig;

  // Ready only looks at the other channel's valid, never at its own.
  assign rd_ready = rd_elig && (!wr_req || rr_read);
  assign wr_ready = wr_elig && (!rd_req || !rr_read);

  assign rd_fire = rd_valid && rd_ready;
  assign wr_fire = wr_valid && wr_ready;

  assign rsp_valid = (state == ST_RSP);
  assign rsp_data  = rsp_zero ? '0 : sram_q;

  // SRAM pins follow the op accepted this cycle; out-of-range requests are
  // accepted but leave the SRAM disabled. An accumulate starts as a read.
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (rd_fire) begin
      if (!rd_oor) begin
        sram_cen = 1'b0;
        sram_a   = rd_addr;
      end
    end else if (wr_fire && !wr_oor) begin
      sram_cen = 1'b0;
      sram_a   = wr_addr;
      if (!acc_req) begin
        sram_wen = 1'b0;
        sram_d   = wr_data;
      end
    end
`ifdef PSUM_ACC_EN
    if (state == ST_ACC_WR) begin
      sram_cen = 1'b0;
      sram_wen = 1'b0;
      sram_a   = acc_addr;
      sram_d   = acc_sum;
    end
`endif
  end

  // Controller FSM plus its registered side outputs. The round-robin pointer
  // hands the next tie to whichever channel did not win the last accepted op.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      rr_read  <= 1'b1;
      rsp_zero <= 1'b0;
      addr_err <= 1'b0;
`ifdef PSUM_ACC_EN
      acc_addr <= '0;
      acc_data <= '0;
`endif
    end else begin
      addr_err <= (rd_fire && rd_oor) || (wr_fire && wr_oor);
      if (rd_fire || wr_fire) begin
        rr_read <= wr_fire;
      end
      if (rd_fire) begin
        rsp_zero <= rd_oor;
      end
      case (state)
        ST_IDLE: begin
          if (rd_fire) begin
            state <= ST_RSP;
          end
`ifdef PSUM_ACC_EN
          else if (wr_fire && acc_req && !wr_oor) begin
            state    <= ST_ACC_WR;
            acc_addr <= wr_addr;
            acc_data <= wr_data;
          end
`endif
        end
        ST_RSP: begin
          if (rsp_ready && !rd_fire) begin
            state <= ST_IDLE;
          end
        end
`ifdef PSUM_ACC_EN
        ST_ACC_WR: begin
          state <= ST_IDLE;
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_sram_ctrl.sv
// tb_psum_sram_ctrl
// Directed bench for psum_sram_ctrl with a behavioural single-port SRAM.
// Read expectations are queued when a read is accepted and a monitor pops
// and compares them whenever a response is consumed. PSUM_ACC_EN enables
// the accumulate scenarios.
module tb_psum_sram_ctrl;

  localparam int BW = 160;
  localparam int AW = 4;

  logic          CLK;
  logic          RESET;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_data;
  logic          wr_acc;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [BW-1:0] rsp_data;
  logic          addr_err;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [BW-1:0] sram_d;
  logic [BW-1:0] sram_q;

  logic [BW-1:0] mem [0:15];
  logic          loaded = 1'b0;
  logic [BW-1:0] sb [$];
  int            tests_run = 0;
  int            tests_failed = 0;

  localparam logic [BW-1:0] WORD_A   = 160'h0A;
  localparam logic [BW-1:0] WORD_W5  = {8{20'h55555}};
  localparam logic [BW-1:0] ACC_INIT = {20'h7FFFF, 120'h0, 20'hFFFFB};
  localparam logic [BW-1:0] ACC_INC  = {20'h00001, 120'h0, 20'h00007};
  localparam logic [BW-1:0] ACC_RES  = {20'h80000, 120'h0, 20'h00002};

  psum_sram_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_acc    (wr_acc),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .addr_err  (addr_err),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Preload pattern: every lane of entry i holds 0x00100 + i.
  function automatic logic [BW-1:0] pre_word(input int i);
    return {8{20'h00100 + 20'(i)}};
  endfunction

  // Single-port SRAM: write on cen=0/wen=0, registered read on cen=0/wen=1,
  // Q holds otherwise.
  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= pre_word(i);
      sram_q <= '0;
      loaded <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q <= mem[sram_a];
    end
  end

  task automatic check_output(input string name, input logic [BW-1:0] actual,
                              input logic [BW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wv, input logic [AW-1:0] wa,
                                input logic [BW-1:0] wd, input logic wacc,
                                input logic rv, input logic [AW-1:0] ra,
                                input logic rr);
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    wr_acc    = wacc;
    rd_valid  = rv;
    rd_addr   = ra;
    rsp_ready = rr;
  endtask

  // Called at the negedge: queue the expected response if a read is being
  // accepted, then move to just after the next rising edge.
  task automatic end_cycle(input logic [BW-1:0] exp_rd);
    if (rd_valid && rd_ready) sb.push_back(exp_rd);
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    sb.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  // Response monitor
  always @(negedge CLK) begin
    if (!RESET && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL rsp_unexpected: actual=%h required=no response", rsp_data);
      end else begin
        check_output("rsp_data", rsp_data, sb.pop_front());
      end
    end
  end

  initial begin
    RESET = 1'b0;
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2 RESET = 1'b1;

    // Reset state
    @(negedge CLK);
    check_output("rst_rsp_valid", BW'(rsp_valid), 1'b0);
    check_output("rst_addr_err", BW'(addr_err), 1'b0);
    check_output("rst_cen", BW'(sram_cen), 1'b1);
    check_output("rst_wen", BW'(sram_wen), 1'b1);
    check_output("rst_a", BW'(sram_a), '0);
    check_output("rst_d", sram_d, '0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Plain write a3, then read it back
    apply_stimulus(1'b1, 4'd3, WORD_A, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    check_output("t1_wr_ready", BW'(wr_ready), 1'b1);
    check_output("t1_wr_cen", BW'(sram_cen), 1'b0);
    check_output("t1_wr_wen", BW'(sram_wen), 1'b0);
    check_output("t1_wr_a", BW'(sram_a), 160'd3);
    check_output("t1_wr_d", sram_d, WORD_A);
    end_cycle('0);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd3, 1'b1);
    @(negedge CLK);
    check_output("t1_rd_ready", BW'(rd_ready), 1'b1);
    check_output("t1_rd_cen", BW'(sram_cen), 1'b0);
    check_output("t1_rd_wen", BW'(sram_wen), 1'b1);
    check_output("t1_rd_a", BW'(sram_a), 160'd3);
    end_cycle(WORD_A);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    check_output("t1_rsp_valid_t1", BW'(rsp_valid), 1'b1);
    check_output("t1_single_cen", BW'(sram_cen), 1'b1);
    end_cycle('0);
    @(negedge CLK);
    check_output("t1_rsp_done", BW'(rsp_valid), 1'b0);
    end_cycle('0);

    // Back-to-back reads with the consumer stalled for 3 cycles
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd0, 1'b0);
    @(negedge CLK);
    check_output("t2_rd_ready_a0", BW'(rd_ready), 1'b1);
    end_cycle(pre_word(0));
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_output("t2_stall_rd_ready", BW'(rd_ready), 1'b0);
      check_output("t2_stall_rsp_valid", BW'(rsp_valid), 1'b1);
      check_output("t2_stall_rsp_data", rsp_data, pre_word(0));
      end_cycle(pre_word(1));
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    check_output("t2_rd_ready_a1", BW'(rd_ready), 1'b1);
    end_cycle(pre_word(1));
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd2, 1'b1);
    @(negedge CLK);
    check_output("t2_rd_ready_a2", BW'(rd_ready), 1'b1);
    end_cycle(pre_word(2));
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    check_output("t2_last_rsp", BW'(rsp_valid), 1'b1);
    end_cycle('0);
    @(negedge CLK);
    check_output("t2_idle", BW'(rsp_valid), 1'b0);
    end_cycle('0);

    // Both channels valid for 4 cycles: read, write, read, write
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    apply_reset();
    apply_stimulus(1'b1, 4'd5, WORD_W5, 1'b0, 1'b1, 4'd4, 1'b1);
    begin
      logic [3:0] rd_win;
      rd_win = 4'b0101;
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        check_output("t3_rd_ready", BW'(rd_ready), BW'(rd_win[i]));
        check_output("t3_wr_ready", BW'(wr_ready), BW'(!rd_win[i]));
        check_output("t3_wen", BW'(sram_wen), BW'(rd_win[i]));
        check_output("t3_cen", BW'(sram_cen), 1'b0);
        end_cycle(pre_word(4));
      end
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd5, 1'b1);
    @(negedge CLK);
    check_output("t3_idle_after", BW'(rsp_valid), 1'b0);
    end_cycle(WORD_W5);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    end_cycle('0);

    // Out-of-range read a9 and write a12
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd9, 1'b1);
    @(negedge CLK);
    check_output("t4_rd_ready", BW'(rd_ready), 1'b1);
    check_output("t4_rd_cen", BW'(sram_cen), 1'b1);
    end_cycle('0);
    apply_stimulus(1'b1, 4'd12, WORD_W5, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    check_output("t4_err_rd", BW'(addr_err), 1'b1);
    check_output("t4_rsp_valid", BW'(rsp_valid), 1'b1);
    check_output("t4_wr_ready", BW'(wr_ready), 1'b1);
    check_output("t4_wr_cen", BW'(sram_cen), 1'b1);
    end_cycle('0);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    check_output("t4_err_wr", BW'(addr_err), 1'b1);
    check_output("t4_rsp_done", BW'(rsp_valid), 1'b0);
    end_cycle('0);
    @(negedge CLK);
    check_output("t4_err_clear", BW'(addr_err), 1'b0);
    end_cycle('0);

    // Reset while a response is pending
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd1, 1'b0);
    @(negedge CLK);
    end_cycle(pre_word(1));
    check_output("t6_rsp_pending", BW'(rsp_valid), 1'b1);
    RESET = 1'b1;
    #1;
    check_output("t6_rst_rsp_valid", BW'(rsp_valid), 1'b0);
    check_output("t6_rst_cen", BW'(sram_cen), 1'b1);
    check_output("t6_rst_rd_ready", BW'(rd_ready), 1'b0);
    sb.delete();
    @(posedge CLK);
    #1;
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    RESET = 1'b0;
    @(negedge CLK);
    check_output("t6_post_rst_idle", BW'(rsp_valid), 1'b0);
    end_cycle('0);

`ifdef PSUM_ACC_EN
    // Accumulate into a2 with signed wrap in lanes 0 and 7
    apply_stimulus(1'b1, 4'd2, ACC_INIT, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    end_cycle('0);
    apply_stimulus(1'b1, 4'd2, ACC_INC, 1'b1, 1'b0, '0, 1'b1);
    @(negedge CLK);
    check_output("t5_acc_ready", BW'(wr_ready), 1'b1);
    check_output("t5_acc_rd_wen", BW'(sram_wen), 1'b1);
    check_output("t5_acc_rd_cen", BW'(sram_cen), 1'b0);
    end_cycle('0);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd2, 1'b1);
    @(negedge CLK);
    check_output("t5_accwr_cen", BW'(sram_cen), 1'b0);
    check_output("t5_accwr_wen", BW'(sram_wen), 1'b0);
    check_output("t5_accwr_a", BW'(sram_a), 160'd2);
    check_output("t5_accwr_d", sram_d, ACC_RES);
    check_output("t5_accwr_rd_ready", BW'(rd_ready), 1'b0);
    end_cycle('0);
    @(negedge CLK);
    check_output("t5_accwr_one_cycle", BW'(sram_wen), 1'b1);
    end_cycle(ACC_RES);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    end_cycle('0);

    // Reset during ACC_WR leaves a6 untouched
    apply_stimulus(1'b1, 4'd6, ACC_INC, 1'b1, 1'b0, '0, 1'b1);
    @(negedge CLK);
    end_cycle('0);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    check_output("t6_accwr_active", BW'(sram_cen), 1'b0);
    RESET = 1'b1;
    #1;
    check_output("t6_accwr_rst_cen", BW'(sram_cen), 1'b1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 4'd6, 1'b1);
    @(negedge CLK);
    end_cycle(pre_word(6));
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    end_cycle('0);
`endif

    @(negedge CLK);
    check_output("sb_drained", BW'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
